depacketer: RTL
===============

# depacketer

Receive-side counterpart of the node's flit packeter. Accepts 82-bit collective-router flits from the ejection port, discards any flit whose destination coordinates do not match this node, and buffers matching flits in a small FIFO. Exposes the decoded header fields and payload to the local collective engine over a valid/ready handshake. Keeps saturating accept/drop statistics for debug.

## Interface
- cur_rank, 9'b0, this node's rank (informational; not used for filtering)
- rank_x, 3'b0, this node's X coordinate
- rank_y, 3'b0, this node's Y coordinate
- rank_z, 3'b0, this node's Z coordinate
- FlitWidth, 82, flit width
- FifoDepth, 4, buffered flits; must be a power of two ≥2
- CountWidth, 16, statistics counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flit_in  in  82  flit. Layout: [81] valid, [80:78] dst_z, [77:75] dst_y, [74:72] dst_x, [71:69] src_z, [68:66] src_y, [65:63] src_x, [62:54] rank, [53:46] contextId, [45:38] tag, [37:36] algtype, [35:32] op, [31:0] payload
- in_ready  out  1  depacketer can consume flit_in this cycle
- out_valid  out  1  head flit available
- out_ready  in  1  consumer takes head flit
- payload  out  32  head payload
- op  out  4  head op
- algtype  out  2  head algtype
- tag  out  8  head tag
- contextId  out  8  head contextId
- rank  out  9  head rank
- src_x, src_y, src_z  out  3 each  head source coordinates
- accept_count  out  CountWidth  flits written to FIFO
- drop_count  out  CountWidth  flits discarded on address mismatch

## Operation
- Consume event: flit_in[81]=1 and in_ready=1. A flit with bit 81=0 is never consumed and never counted.
- Address match: flit_in[74:72]==rank_x, [77:75]==rank_y, [80:78]==rank_z.
- On consume with match: store flit bits [71:0] at write pointer, advance pointer (wraps mod FifoDepth), increment accept_count.
- On consume with mismatch: nothing stored, increment drop_count.
- Counters saturate at all-ones; never wrap.
- in_ready = FIFO not full. Upstream holds the flit while in_ready=0. Mismatched flits also wait when full (no bypass).
- out_valid = FIFO not empty. Output fields decode combinationally from the head entry.
- Pop event: out_valid=1 and out_ready=1. Advance read pointer (wraps).
- Occupancy counter 0..FifoDepth. Push and pop in the same cycle leave it unchanged.
- Full: occupancy==FifoDepth. A pop in a full cycle does not raise in_ready in that same cycle; in_ready rises on the next cycle.
- Empty: a push in an empty cycle does not raise out_valid in that cycle (no fall-through).
- Field outputs are don't-care-stable when out_valid=0. They must hold the last head entry and must not show X.

## Timing
- Reset (async assert, sync-released by the surrounding logic): read/write pointers=0, occupancy=0, counters=0, all storage entries=0.
- Outputs in reset: in_ready=1, out_valid=0, all field outputs=0, accept_count=0, drop_count=0.
- Latency: a flit consumed at edge N appears at the head with out_valid=1 after edge N, provided the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: one consume and one pop per cycle sustained.
- accept_count and drop_count update on the same edge as the consume.
- Reset mid-operation: all buffered flits are lost immediately and counters clear. No partial state survives.
- in_ready and out_valid depend only on registered state, never combinationally on flit_in or out_ready.

## Test plan
- Reset: assert rst_n=0 mid-stream with 2 flits buffered -> immediately out_valid=0, in_ready=1, both counters 0; after release FIFO is empty.
- Single match: rank_x/y/z=1/2/3; drive a flit with dst 1/2/3, payload 0xDEADBEEF, op 4'h5, tag 8'hA5 for one cycle, out_ready=0 -> next cycle out_valid=1, payload=0xDEADBEEF, op=5, tag=A5; accept_count=1.
- Mismatch: dst_x=0 with node 1/2/3 -> no out_valid; drop_count=1, accept_count unchanged.
- Valid bit clear: flit with [81]=0 held 10 cycles -> both counters stay 0, out_valid stays 0.
- Full/backpressure: out_ready=0, stream 5 matching flits payload 1..5 -> in_ready=0 after 4 consumes and flit 5 is held. Raise out_ready for one cycle -> pop payload 1, in_ready=1 the next cycle, flit 5 consumed, order 2,3,4,5 preserved.
- Simultaneous push/pop plus saturation: continuous matching flits with out_ready=1 -> occupancy stays at 1 and one pop per cycle. With CountWidth=4, 20 consumes -> accept_count holds 4'hF.

Source files
------------

// File: rtl/depacketer.sv
// depacketer: ejection-port flit filter and FIFO for the local collective engine.
// Flits whose destination coordinates differ from this node's coordinates are
// counted and discarded. Matching flits are buffered, and their header fields
// are decoded from the head entry of the FIFO.
module depacketer #(
   parameter logic [8:0] cur_rank   = 9'd0,
   parameter logic [2:0] rank_x     = 3'd0,
   parameter logic [2:0] rank_y     = 3'd0,
   parameter logic [2:0] rank_z     = 3'd0,
   parameter int         FlitWidth  = 82,
   parameter int         FifoDepth  = 4,
   parameter int         CountWidth = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FlitWidth-1:0]  flit_in,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           payload,
   output logic [3:0]            op,
   output logic [1:0]            algtype,
   output logic [7:0]            tag,
   output logic [7:0]            contextId,
   output logic [8:0]            rank,
   output logic [2:0]            src_x,
   output logic [2:0]            src_y,
   output logic [2:0]            src_z,
   output logic [CountWidth-1:0] accept_count,
   output logic [CountWidth-1:0] drop_count
);

   localparam int PtrW = $clog2(FifoDepth);
   localparam int OccW = $clog2(FifoDepth + 1);

   // Stop elaboration on a malformed build: the depth must be a power of two
   // so that the pointers wrap naturally, and the flit layout is fixed.
   if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0 || FlitWidth != 82 ||
       $bits(cur_rank) != 9) begin : g_bad_cfg
      $error("depacketer: unsupported parameter set");
   end

   // Low 72 flit bits, kept in their wire order.
   typedef struct packed {
      logic [2:0]  sz;
      logic [2:0]  sy;
      logic [2:0]  sx;
      logic [8:0]  rk;
      logic [7:0]  ctx;
      logic [7:0]  tg;
      logic [1:0]  alg;
      logic [3:0]  opc;
      logic [31:0] pl;
   } entry_t;

   entry_t          mem [FifoDepth];
   entry_t          last_q;
   entry_t          head;
   logic [PtrW-1:0] wr_ptr, rd_ptr;
   logic [OccW-1:0] occ;
   logic            full, empty, hit, consume, push, drop, pop;

   assign full    = (occ == OccW'(FifoDepth));
   assign empty   = (occ == '0);
   assign hit     = (flit_in[74:72] == rank_x) && (flit_in[77:75] == rank_y) &&
                    (flit_in[80:78] == rank_z);
   // Both handshakes are gated only by registered occupancy. A pop in a full
   // cycle therefore frees space only on the next cycle.
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign consume   = flit_in[81] && in_ready;
   assign push      = consume && hit;
   assign drop      = consume && !hit;
   assign pop       = out_valid && out_ready;

   // While the FIFO is empty, hold the last popped head so that the fields stay stable.
   assign head      = out_valid ? mem[rd_ptr] : last_q;
   assign payload   = head.pl;
   assign op        = head.opc;
   assign algtype   = head.alg;
   assign tag       = head.tg;
   assign contextId = head.ctx;
   assign rank      = head.rk;
   assign src_x     = head.sx;
   assign src_y     = head.sy;
   assign src_z     = head.sz;

   // FIFO storage. Every entry is cleared on reset, so the field outputs never show X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FifoDepth; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= entry_t'(flit_in[71:0]);
      end
   end

   // Pointers, occupancy and the held copy of the last head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         last_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PtrW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + PtrW'(1);
            last_q <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   occ <= occ + OccW'(1);
            2'b01:   occ <= occ - OccW'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Saturating debug statistics. They update on the same edge as the consume.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accept_count <= '0;
         drop_count   <= '0;
      end else begin
         if (push && accept_count != '1) accept_count <= accept_count + CountWidth'(1);
         if (drop && drop_count != '1)   drop_count   <= drop_count + CountWidth'(1);
      end
   end

endmodule
